plic_prio_arbiter: RTL
======================

Name: plic_prio_arbiter

Overview:
- Parametrised successor to the PLIC priority determiner: arbitrates NUM_SRC interrupt sources with per-source gateways, enable mask, priority threshold and a claim/complete handshake.
- Sits between the peripheral IRQ lines and the CPU interrupt input.
- Raises intr_ev for the highest-priority eligible source and exposes its ID for the CPU to claim.

Parameters:
- NUM_SRC, 8, number of interrupt sources; IDs are 1..NUM_SRC, ID 0 means "none".
- PRIO_W, 3, priority field width; priority 0 means "never interrupt".
- ID_W, 4, width of ID fields; must satisfy 2^ID_W > NUM_SRC.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- irq_req  in  NUM_SRC  raw requests; bit i = source ID i+1.
- src_prio  in  NUM_SRC*PRIO_W  packed priorities; source i uses bits [i*PRIO_W +: PRIO_W].
- src_en  in  NUM_SRC  per-source enable.
- edge_mode  in  NUM_SRC  1 = rising-edge triggered, 0 = level triggered.
- threshold  in  PRIO_W  only priorities strictly greater than this interrupt.
- I_flag  in  1  global interrupt enable from CPU.
- claim  in  1  single-cycle claim pulse.
- complete  in  1  single-cycle completion pulse.
- complete_id  in  ID_W  ID being completed.
- intr_ev  out  1  interrupt request to CPU (registered).
- claim_id  out  ID_W  registered winning ID, 0 if none.

Behaviour:
- Reset (preset=1 at an edge):
  - Clears pending, in_service, the edge-detect history, claim_id and intr_ev, all to 0.
  - Reset mid-claim discards all in-service state.
- Gateway per source i:
  - Level mode: pending[i] is set at an edge where irq_req[i]=1 and in_service[i]=0.
  - Edge mode: pending[i] is set at an edge where irq_req[i]=1, the previous sample was 0, and in_service[i]=0.
  - Requests arriving while in_service[i]=1 are ignored; edges are lost and level requests re-pend after completion.
  - pending[i] clears only on a claim of ID i+1. Dropping irq_req does not clear it.
- Eligibility: pending[i] & src_en[i] & (prio[i] > threshold). Comparison is unsigned, so prio 0 is never eligible.
- Winner selection:
  - Highest priority wins; ties go to the lowest index.
  - The winner is registered into claim_id every cycle.
  - intr_ev <= (any eligible) & I_flag.
- Latency:
  - irq_req first sampled high at edge t sets pending at t.
  - claim_id and intr_ev are valid after edge t+1.
  - Config changes (prio, en, threshold, I_flag) are reflected after one edge.
- Claim:
  - At an edge with claim=1 and claim_id≠0, pending[claim_id] clears and in_service[claim_id] sets.
  - At the same edge, claim_id and intr_ev load 0, so there is no stale re-claim.
  - Arbitration resumes at the following edge.
  - Claim with claim_id=0 has no effect.
- Complete:
  - At an edge with complete=1, in_service[complete_id] clears, provided 1 ≤ complete_id ≤ NUM_SRC and the bit is set.
  - Otherwise complete is ignored.
- Simultaneous events:
  - Claim of A and complete of B at the same edge: both take effect.
  - Pending-set and claim of the same source at the same edge: the claim wins, and the source ends in service with pending cleared.
  - Complete of A while A's level request is still high: A re-pends at the next edge.
- No state machine beyond the per-source pending/in_service pair. The states are IDLE (0,0), PENDING (1,0) and IN_SERVICE (0,1). The combination (1,1) is unreachable.

Test Plan:
- Reset then idle: all irq_req=0, I_flag=1, preset pulse → claim_id=0 and intr_ev=0 on every cycle.
- Single source, level: src 3 prio=5, threshold=2, en, irq_req[2] high at edge t → claim_id=3 and intr_ev=1 after t+1; claim → both 0 next edge; complete_id=3 with request still high → intr_ev=1 two edges later.
- Priority and tie: sources 2 and 6 prio=4, source 5 prio=6, all pending → claim_id=5; claim 5 → next winner 2 (tie, lowest index), then 6.
- Threshold, enable, I_flag: src 1 prio=3, threshold=3 → no interrupt; threshold=2 → claim_id=1; src_en[0]=0 → claim_id=0; I_flag=0 with an eligible source → intr_ev=0 while claim_id≠0.
- Edge mode: src 4 edge, pulse irq_req high 1 cycle → pending latched, claim_id=4; claim; second pulse while in service → lost; after complete_id=4 no interrupt.
- Corner cases: claim with claim_id=0 → no change; complete_id=0 or 9 → ignored; claim 2 and complete 7 at the same edge → 2 in service, 7 released.

Source files
------------

// File: rtl/plic_prio_arbiter.sv
// PLIC-style priority arbiter: per-source gateways, enable/threshold filtering and
// a claim/complete handshake that presents the highest-priority eligible source ID.
module plic_prio_arbiter #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3,
    parameter int unsigned ID_W    = 4
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic [NUM_SRC-1:0]         irq_req,
    input  logic [NUM_SRC*PRIO_W-1:0]  src_prio,
    input  logic [NUM_SRC-1:0]         src_en,
    input  logic [NUM_SRC-1:0]         edge_mode,
    input  logic [PRIO_W-1:0]          threshold,
    input  logic                       I_flag,
    input  logic                       claim,
    input  logic                       complete,
    input  logic [ID_W-1:0]            complete_id,
    output logic                       intr_ev,
    output logic [ID_W-1:0]            claim_id
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] req_prev;

    logic [NUM_SRC-1:0] trig;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] in_service_nxt;
    logic [NUM_SRC-1:0] eligible;
    logic               claim_hit;
    logic               complete_hit;
    logic [PRIO_W-1:0]  cur_prio;
    logic [PRIO_W-1:0]  win_prio;
    logic [ID_W-1:0]    win_id;
    logic               win_any;

    // A claim only acts on a real winner; completes outside 1..NUM_SRC are dropped.
    assign claim_hit    = claim && (claim_id != '0);
    assign complete_hit = complete && (complete_id != '0) && (complete_id <= ID_W'(NUM_SRC));

    // Gateway: edge sources need a 0->1 transition, everything is masked while in service.
    assign trig = irq_req & ~in_service & (~edge_mode | ~req_prev);

    // Claim is applied after the gateway so a same-edge set loses to the claim.
    always_comb begin
        pending_nxt    = pending | trig;
        in_service_nxt = in_service;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (complete_hit && (complete_id == ID_W'(i + 1))) begin
                in_service_nxt[i] = 1'b0;
            end
            if (claim_hit && (claim_id == ID_W'(i + 1))) begin
                pending_nxt[i]    = 1'b0;
                in_service_nxt[i] = 1'b1;
            end
        end
    end

    // Strictly-greater update keeps the lowest index on priority ties.
    always_comb begin
        eligible = '0;
        cur_prio = '0;
        win_prio = '0;
        win_id   = '0;
        win_any  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_prio    = src_prio[i*PRIO_W +: PRIO_W];
            eligible[i] = pending[i] & src_en[i] & (cur_prio > threshold);
            if (eligible[i] && (!win_any || (cur_prio > win_prio))) begin
                win_any  = 1'b1;
                win_prio = cur_prio;
                win_id   = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            pending    <= '0;
            in_service <= '0;
            req_prev   <= '0;
            claim_id   <= '0;
            intr_ev    <= 1'b0;
        end else begin
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
            req_prev   <= irq_req;
            // Zero the outputs on a claim so the same ID cannot be claimed twice.
            if (claim_hit) begin
                claim_id <= '0;
                intr_ev  <= 1'b0;
            end else begin
                claim_id <= win_id;
                intr_ev  <= win_any & I_flag;
            end
        end
    end

endmodule
